// File: rtl/rns_symbol_decoder_3b.sv
// Receive-side decoder for the 3-bit RNS symbol link.
// Data symbols pass through; control symbols are mapped back to the
// sel0/sel1/sel2 selection that produced them; illegal control codes are
// flagged. Decoded entries are buffered in a 2-entry FIFO, and saturating
// per-class counters track accepted symbols.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where valid && ready. The producer keeps valid and its payload stable until
// the transfer; the FIFO holds out_valid_o and the head fields stable until
// the head is popped. in_ready_o is registered and independent of out_ready_i.
module rns_symbol_decoder_3b #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_data_i,
    input  logic             in_a_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2:0]       out_data_o,
    output logic             out_sel0_o,
    output logic             out_sel1_o,
    output logic             out_sel2_o,
    output logic             out_is_data_o,
    output logic             out_err_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] data_cnt_o,
    output logic [CNT_W-1:0] ctrl_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [1:0]       dbg_state_o
);

    // Occupancy state; the encoding equals the number of buffered entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    // sel[0] = sel0, sel[1] = sel1, sel[2] = sel2.
    typedef struct packed {
        logic [2:0] data;
        logic [2:0] sel;
        logic       is_data;
        logic       err;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    occ_e             state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             in_ready_q;
    entry_t           mem0_q, mem1_q;
    entry_t           head_q, head_d;
    entry_t           dec;
    entry_t           mem_rd;
    logic             push, pop;
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign push        = in_valid_i && in_ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign pop         = out_valid_o && out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign dbg_state_o = state_q;

    // Decode the incoming symbol into a FIFO entry.
    always_comb begin
        dec         = '0;
        dec.data    = in_data_i;
        if (in_a_i) begin
            dec.is_data = 1'b1;
        end else begin
            unique case (in_data_i)
                3'b101:  dec.sel = 3'b000;
                3'b100:  dec.sel = 3'b001;
                3'b011:  dec.sel = 3'b010;
                3'b010:  dec.sel = 3'b100;
                default: dec.err = 1'b1;
            endcase
        end
    end

    // Occupancy next-state and pointer advance.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        unique case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_d = ST_FULL;
                else if (pop && !push) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Select the stored entry that will be at the head after this edge.
    always_comb begin
        mem_rd = rd_ptr_d ? mem1_q : mem0_q;
    end

    // Head register: follows the new head, holds its value when the FIFO drains.
    always_comb begin
        head_d = head_q;
        if (state_d != ST_EMPTY) begin
            if (push && (wr_ptr_q == rd_ptr_d)) head_d = dec;
            else                                head_d = mem_rd;
        end
    end

    // Saturating per-class counters; clear wins over an increment.
    always_comb begin
        data_cnt_d = data_cnt_q;
        ctrl_cnt_d = ctrl_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clr_cnt_i) begin
            data_cnt_d = '0;
            ctrl_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (push) begin
            if (dec.is_data) begin
                if (data_cnt_q != CNT_MAX) data_cnt_d = data_cnt_q + CNT_ONE;
            end else if (dec.err) begin
                if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
            end else begin
                if (ctrl_cnt_q != CNT_MAX) ctrl_cnt_d = ctrl_cnt_q + CNT_ONE;
            end
        end
    end

    // Occupancy, pointers and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // FIFO storage and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q <= '0;
            mem1_q <= '0;
            head_q <= '0;
        end else begin
            if (push && !wr_ptr_q) mem0_q <= dec;
            if (push && wr_ptr_q)  mem1_q <= dec;
            head_q <= head_d;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cnt_q <= '0;
            ctrl_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            data_cnt_q <= data_cnt_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_data_o    = head_q.data;
    assign out_sel0_o    = head_q.sel[0];
    assign out_sel1_o    = head_q.sel[1];
    assign out_sel2_o    = head_q.sel[2];
    assign out_is_data_o = head_q.is_data;
    assign out_err_o     = head_q.err;
    assign data_cnt_o    = data_cnt_q;
    assign ctrl_cnt_o    = ctrl_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: doc/rns_symbol_decoder_3b.md
# rns_symbol_decoder_3b

Receive-side decoder for the 3-bit RNS symbol link. Accepts 3-bit symbols with their data/control flag `a`. Data symbols pass through unchanged. Control symbols are mapped back to the `sel0/sel1/sel2` selection that produced them. Results are buffered in a 2-entry output FIFO with valid/ready handshakes on both sides, and saturating per-class symbol counters are maintained for link monitoring.

## Interface
- `CNT_W`, 8: width of each statistics counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream symbol present.
- `in_ready`  out  1  decoder can accept a symbol this cycle.
- `in_data`  in  3  received symbol.
- `in_a`  in  1  1 = data symbol, 0 = control symbol.
- `out_valid`  out  1  decoded entry available at the FIFO head.
- `out_ready`  in  1  downstream consumes the head entry.
- `out_data`  out  3  payload; raw symbol for control or error entries.
- `out_sel0`, `out_sel1`, `out_sel2`  out  1 each  recovered selection, at most one high.
- `out_is_data`  out  1  head entry is a data symbol.
- `out_err`  out  1  head entry is an illegal control code.
- `clr_cnt`  in  1  synchronous clear of all counters.
- `data_cnt`, `ctrl_cnt`, `err_cnt`  out  `CNT_W` each  saturating counts of accepted symbols by class.

## Operation
- **Accept:** a symbol is accepted when `in_valid && in_ready` at a rising edge.
- **Decode** (combinational on the input, result written into the FIFO):
  - `in_a=1`: `data=in_data`, `sel=000`, `is_data=1`, `err=0`.
  - `in_a=0`, `in_data=3'b101`: no select; all `sel` low, `is_data=0`, `err=0`.
  - `in_a=0`, `in_data=3'b100`: `sel0=1`.
  - `in_a=0`, `in_data=3'b011`: `sel1=1`.
  - `in_a=0`, `in_data=3'b010`: `sel2=1`.
  - `in_a=0`, `in_data` ∈ {000, 001, 110, 111}: `err=1`, all `sel` low, `is_data=0`.
  - All control and error entries carry the raw symbol on `out_data`.
- **FIFO:**
  - 2 entries, each holding `{data[2:0], sel[2:0], is_data, err}`.
  - Write/read pointers are 1 bit each, plus a 2-bit occupancy count (0..2).
  - `in_ready = (count != 2)`, a registered decode of the count. There is no combinational path from `out_ready` to `in_ready`.
  - `out_valid = (count != 0)`. The head entry drives the `out_*` fields.
  - A pop occurs on `out_valid && out_ready`.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When empty, `out_*` fields hold their last values. They are don't-care while `out_valid=0`, but must be stable, not X, after reset.
- **Counters:**
  - On each accept, exactly one counter increments: `data_cnt` if `in_a=1`, `err_cnt` if illegal control, otherwise `ctrl_cnt`.
  - Each counter saturates at 2^`CNT_W`-1 and holds there.
  - `clr_cnt=1` sets all three to 0 that cycle. Clear wins over a simultaneous increment.
- **State of FIFO occupancy:** EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - ONE→ONE on push+pop.
  - FULL→ONE on pop. Push is impossible in FULL.
- **Reset:**
  - Count 0, pointers 0.
  - `in_ready=1`, `out_valid=0`.
  - All `out_*` fields 0, all counters 0.
  - Reset asserted mid-stream discards buffered entries immediately, asynchronously.

## Timing
- Latency: a symbol accepted at edge k appears at the head with `out_valid=1` after edge k, when the FIFO was empty.
- Throughput: 1 symbol/cycle sustained while `out_ready=1`.
- `in_ready` deasserts the cycle after the FIFO reaches FULL. It reasserts the cycle after the first pop from FULL.
- A held `out_valid` with its `out_*` fields must remain stable until the entry is popped.
- Counters update at the accept edge and are visible the following cycle.
- `rst_n` deassertion is assumed synchronized externally. The first accept is allowed on the first edge with `rst_n=1`.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with 2 entries buffered → `out_valid=0`, `in_ready=1`, all counters 0, all outputs 0 immediately.
- **Control decode:** with `out_ready=1`, send `a=0` symbols 101, 100, 011, 010 → one cycle later each: `sel=000`, `sel0`, `sel1`, `sel2` respectively; `out_is_data=0`, `out_err=0`; `ctrl_cnt=4`.
- **Data and error:** send `a=1` 110 and `a=0` 111 → first `out_data=110`, `out_is_data=1`; second `out_err=1`, `out_data=111`, `sel` all low; `data_cnt=1`, `err_cnt=1`.
- **Backpressure:** hold `out_ready=0` and send 3 symbols → first two accepted, `in_ready=0` with the third held. Release `out_ready` → entries emerge in order with no loss or duplication. Push+pop in ONE keeps the count at 1.
- **Saturation and clear:** with `CNT_W=2`, send 5 data symbols → `data_cnt=3`. Pulse `clr_cnt` together with a control-symbol accept → all counters 0 the next cycle.
- **Random soak:** random `in_valid`, `out_ready`, `in_a`, and symbols over 10k cycles, checked against a scoreboard → every accepted symbol is decoded correctly, in order, and the counters match.
